// File: rtl/fft_pkg.sv
// fft_pkg
// Shared constants and helpers for the FFT output reorder buffer.
//   FFT_DW / FFT_N / FFT_P : default sample width, frame length, lanes per beat
//   bitrev(value, nbits)   : reverse the low nbits of value (upper bits return 0)
package fft_pkg;

    localparam int FFT_DW = 13;
    localparam int FFT_N  = 512;
    localparam int FFT_P  = 16;

    // Shift the low nbits of value out LSB-first into the result, which reverses them
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int nbits);
        logic [31:0] src;
        logic [31:0] res;
        src = value;
        res = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                res = {res[30:0], src[0]};
                src = {1'b0, src[31:1]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_rb_bank.sv
// fft_rb_bank
// One frame of complex sample storage for the reorder buffer.
//   clk              : clock
//   wr_en            : write one beat (P samples) at wr_beat
//   wr_beat          : beat address, lane l goes to sample wr_beat*P+l
//   wr_i, wr_q       : P packed samples, lane l at [l*DW +: DW]
//   rd_beat, rd_mode : beat to read; mode 1 reads sample bitrev(rd_beat*P+m) into lane m
//   rd_i, rd_q       : P packed samples (combinational read)
// Storage is deliberately not reset: a bank is only read after being fully written.
module fft_rb_bank
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int N  = FFT_N,
    parameter int P  = FFT_P,
    localparam int BEATS = N / P,
    localparam int BW    = $clog2(BEATS),
    localparam int AW    = $clog2(N)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [BW-1:0]     wr_beat,
    input  logic [P*DW-1:0]   wr_i,
    input  logic [P*DW-1:0]   wr_q,
    input  logic [BW-1:0]     rd_beat,
    input  logic              rd_mode,
    output logic [P*DW-1:0]   rd_i,
    output logic [P*DW-1:0]   rd_q
);

    logic [DW-1:0] mem_i [N];
    logic [DW-1:0] mem_q [N];

    // Sample store: lane l of beat b lands at natural sample address b*P+l
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < P; l++) begin
                mem_i[AW'(int'(wr_beat) * P + l)] <= wr_i[l*DW +: DW];
                mem_q[AW'(int'(wr_beat) * P + l)] <= wr_q[l*DW +: DW];
            end
        end
    end

    // Read crossbar: every lane picks its own sample, natural or bit-reversed index
    always_comb begin : rd_xbar
        logic [AW-1:0] raddr;
        raddr = {AW{1'b0}};
        rd_i  = {(P*DW){1'b0}};
        rd_q  = {(P*DW){1'b0}};
        for (int m = 0; m < P; m++) begin
            if (rd_mode) begin
                raddr = AW'(bitrev(32'(int'(rd_beat) * P + m), AW));
            end else begin
                raddr = AW'(int'(rd_beat) * P + m);
            end
            rd_i[m*DW +: DW] = mem_i[raddr];
            rd_q[m*DW +: DW] = mem_q[raddr];
        end
    end

endmodule

// File: rtl/fft_reorder_pp.sv
// fft_reorder_pp
// Ping-pong frame buffer that turns bit-reversed FFT output into natural order
// (or passes frames through in order), P complex samples per beat.
//   clk, rst                     : clock, asynchronous active-high reset
//   din_valid/din_ready          : input beat handshake; din_ready = write bank not full
//   din_i, din_q                 : P packed input samples, lane l = sample b*P+l
//   bitrev_en                    : frame mode, captured on the first beat of each frame
//   dout_valid/dout_ready        : output beat handshake
//   dout_i, dout_q, dout_last    : registered output beat, last flags beat N/P-1
module fft_reorder_pp
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int N  = FFT_N,
    parameter int P  = FFT_P
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic signed [P*DW-1:0] din_i,
    input  logic signed [P*DW-1:0] din_q,
    input  logic                 bitrev_en,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic signed [P*DW-1:0] dout_i,
    output logic signed [P*DW-1:0] dout_q,
    output logic                 dout_last
);

    localparam int BEATS = N / P;
    localparam int BW    = $clog2(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic           wr_bank_r;
    logic [BW-1:0]  wr_beat_r;
    logic           rd_bank_r;
    logic [BW-1:0]  rd_beat_r;
    logic [1:0]     full_r;
    logic [1:0]     mode_r;

    logic             dout_valid_r;
    logic             dout_last_r;
    logic [P*DW-1:0]  dout_i_r;
    logic [P*DW-1:0]  dout_q_r;

    logic             din_accept_s;
    logic             wr_done_s;
    logic             rd_load_s;
    logic             rd_done_s;
    logic [1:0]       full_nxt_s;
    logic [P*DW-1:0]  b0_rd_i_s;
    logic [P*DW-1:0]  b0_rd_q_s;
    logic [P*DW-1:0]  b1_rd_i_s;
    logic [P*DW-1:0]  b1_rd_q_s;
    logic [P*DW-1:0]  rd_i_s;
    logic [P*DW-1:0]  rd_q_s;

    assign din_ready  = ~full_r[wr_bank_r];
    assign dout_valid = dout_valid_r;
    assign dout_last  = dout_last_r;
    assign dout_i     = dout_i_r;
    assign dout_q     = dout_q_r;

    // Handshake decode and bank occupancy update. The write side only ever fills
    // an empty bank and the read side only releases a full one, so a fill and a
    // release in the same cycle always touch different banks and both apply.
    always_comb begin
        din_accept_s = din_valid && !full_r[wr_bank_r];
        wr_done_s    = din_accept_s && (wr_beat_r == LAST_BEAT);
        rd_load_s    = full_r[rd_bank_r] && (!dout_valid_r || dout_ready);
        rd_done_s    = rd_load_s && (rd_beat_r == LAST_BEAT);
        full_nxt_s   = full_r;
        full_nxt_s[wr_bank_r] = full_nxt_s[wr_bank_r] | wr_done_s;
        full_nxt_s[rd_bank_r] = full_nxt_s[rd_bank_r] & ~rd_done_s;
        rd_i_s = rd_bank_r ? b1_rd_i_s : b0_rd_i_s;
        rd_q_s = rd_bank_r ? b1_rd_q_s : b0_rd_q_s;
    end

    // Write pointer, per-bank mode capture and occupancy flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_r <= 1'b0;
            wr_beat_r <= {BW{1'b0}};
            full_r    <= 2'b00;
            mode_r    <= 2'b00;
        end else begin
            full_r <= full_nxt_s;
            if (din_accept_s) begin
                if (wr_beat_r == {BW{1'b0}}) begin
                    mode_r[wr_bank_r] <= bitrev_en;
                end
                if (wr_done_s) begin
                    wr_beat_r <= {BW{1'b0}};
                    wr_bank_r <= ~wr_bank_r;
                end else begin
                    wr_beat_r <= wr_beat_r + BW'(1);
                end
            end
        end
    end

    // Read pointer and registered output beat; data holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank_r    <= 1'b0;
            rd_beat_r    <= {BW{1'b0}};
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
            dout_i_r     <= {(P*DW){1'b0}};
            dout_q_r     <= {(P*DW){1'b0}};
        end else if (rd_load_s) begin
            dout_valid_r <= 1'b1;
            dout_last_r  <= (rd_beat_r == LAST_BEAT);
            dout_i_r     <= rd_i_s;
            dout_q_r     <= rd_q_s;
            if (rd_done_s) begin
                rd_beat_r <= {BW{1'b0}};
                rd_bank_r <= ~rd_bank_r;
            end else begin
                rd_beat_r <= rd_beat_r + BW'(1);
            end
        end else if (dout_ready) begin
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
        end
    end

    fft_rb_bank #(.DW(DW), .N(N), .P(P)) u_bank0 (
        .clk     (clk),
        .wr_en   (din_accept_s && !wr_bank_r),
        .wr_beat (wr_beat_r),
        .wr_i    (din_i),
        .wr_q    (din_q),
        .rd_beat (rd_beat_r),
        .rd_mode (mode_r[0]),
        .rd_i    (b0_rd_i_s),
        .rd_q    (b0_rd_q_s)
    );

    fft_rb_bank #(.DW(DW), .N(N), .P(P)) u_bank1 (
        .clk     (clk),
        .wr_en   (din_accept_s && wr_bank_r),
        .wr_beat (wr_beat_r),
        .wr_i    (din_i),
        .wr_q    (din_q),
        .rd_beat (rd_beat_r),
        .rd_mode (mode_r[1]),
        .rd_i    (b1_rd_i_s),
        .rd_q    (b1_rd_q_s)
    );

endmodule

// File: tb/tb_fft_reorder_pp.sv
// tb_fft_reorder_pp
// Directed self-checking bench for fft_reorder_pp at N=512, P=16, DW=13.
module tb_fft_reorder_pp;

    localparam int DW    = 13;
    localparam int N     = 512;
    localparam int P     = 16;
    localparam int BEATS = N / P;
    localparam int LOGN  = 9;
    localparam int VW    = P * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          din_valid;
    logic          din_ready;
    logic [VW-1:0] din_i;
    logic [VW-1:0] din_q;
    logic          bitrev_en;
    logic          dout_valid;
    logic          dout_ready;
    logic [VW-1:0] dout_i;
    logic [VW-1:0] dout_q;
    logic          dout_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_reorder_pp #(.DW(DW), .N(N), .P(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_i      (din_i),
        .din_q      (din_q),
        .bitrev_en  (bitrev_en),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_i     (dout_i),
        .dout_q     (dout_q),
        .dout_last  (dout_last)
    );

    function automatic int brev(input int x);
        int r;
        r = 0;
        for (int i = 0; i < LOGN; i++) begin
            if (((x >> i) & 1) != 0) r = r | (1 << (LOGN - 1 - i));
        end
        return r;
    endfunction

    // Sample s of frame f: I is a ramp offset per frame, Q a negative ramp
    function automatic logic [DW-1:0] smp(input int f, input int s, input bit q);
        int v;
        if (q) v = -s - 1 - 3 * (f % 4);
        else   v = s + 1000 * (f % 4);
        return DW'(v);
    endfunction

    function automatic logic [VW-1:0] in_vec(input int f, input int c, input bit q);
        logic [VW-1:0] v;
        v = '0;
        for (int l = 0; l < P; l++) v[l*DW +: DW] = smp(f, c * P + l, q);
        return v;
    endfunction

    function automatic logic [VW-1:0] out_vec(input int f, input int c, input bit mode, input bit q);
        logic [VW-1:0] v;
        int s;
        v = '0;
        for (int m = 0; m < P; m++) begin
            s = mode ? brev(c * P + m) : c * P + m;
            v[m*DW +: DW] = smp(f, s, q);
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream nfr frames (data ids fbase..) with per-frame modes; dout_ready held
    // low for the first `stall` cycles. Every visible output beat is compared.
    task automatic run_stream(input int fbase, input int nfr, input logic [3:0] modes,
                              input bit toggle, input int stall, input bit strict,
                              input bit expect_drop);
        int tot, in_beat, out_beat, cyc, t_last, first_out, drop_at, f, c;
        bit in_fire, m;
        logic [VW-1:0] lane_v;
        tot = nfr * BEATS;
        in_beat = 0; out_beat = 0; cyc = 0;
        t_last = -1; first_out = -1; drop_at = -1;
        while (out_beat < tot && cyc < 4000) begin
            if (in_beat < tot) begin
                f = in_beat / BEATS;
                c = in_beat % BEATS;
                m = modes[f[1:0]];
                din_valid = 1'b1;
                din_i = in_vec(fbase + f, c, 1'b0);
                din_q = in_vec(fbase + f, c, 1'b1);
                bitrev_en = (c == 0 || !toggle) ? m : ~m;
            end else begin
                din_valid = 1'b0;
                bitrev_en = ~bitrev_en;
            end
            dout_ready = (cyc >= stall);
            if (strict && in_beat < tot) chk("din_ready_high", VW'(din_ready), VW'(1'b1));
            if (expect_drop && !din_ready && drop_at < 0) drop_at = in_beat;
            if (strict && first_out >= 0) chk("dout_contiguous", VW'(dout_valid), VW'(1'b1));
            if (dout_valid) begin
                if (first_out < 0) first_out = cyc;
                f = out_beat / BEATS;
                c = out_beat % BEATS;
                m = modes[f[1:0]];
                chk($sformatf("dout_i f%0d c%0d", fbase + f, c), dout_i, out_vec(fbase + f, c, m, 1'b0));
                chk($sformatf("dout_q f%0d c%0d", fbase + f, c), dout_q, out_vec(fbase + f, c, m, 1'b1));
                chk($sformatf("dout_last f%0d c%0d", fbase + f, c), VW'(dout_last), VW'(c == BEATS - 1));
                if (fbase == 0 && out_beat == 0 && m) begin
                    lane_v = dout_i;
                    chk("beat0_lane0", VW'(lane_v[0*DW +: DW]), VW'(0));
                    chk("beat0_lane1", VW'(lane_v[1*DW +: DW]), VW'(256));
                    chk("beat0_lane2", VW'(lane_v[2*DW +: DW]), VW'(128));
                    chk("beat0_lane3", VW'(lane_v[3*DW +: DW]), VW'(384));
                end
                if (dout_ready) out_beat++;
            end
            in_fire = din_valid && din_ready;
            if (in_fire && in_beat == BEATS - 1) t_last = cyc;
            @(posedge clk); #1;
            if (in_fire) in_beat++;
            cyc++;
        end
        din_valid = 1'b0;
        chk("stream_complete", VW'(out_beat), VW'(tot));
        if (stall == 0) chk("first_out_latency", VW'(first_out - t_last), VW'(2));
        if (expect_drop) chk("din_ready_drop_after", VW'(drop_at), VW'(64));
    endtask

    initial begin
        rst = 1'b1;
        din_valid = 1'b0;
        din_i = '0;
        din_q = '0;
        bitrev_en = 1'b0;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_din_ready", VW'(din_ready), VW'(1'b1));
        chk("rst_dout_valid", VW'(dout_valid), VW'(1'b0));
        chk("rst_dout_last", VW'(dout_last), VW'(1'b0));
        chk("rst_dout_i", dout_i, VW'(0));
        chk("rst_dout_q", dout_q, VW'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Ramp, bit-reversed order
        run_stream(0, 1, 4'b0001, 1'b0, 0, 1'b1, 1'b0);
        // Ramp, natural order, bitrev_en toggled after the first beat
        run_stream(1, 1, 4'b0000, 1'b1, 0, 1'b1, 1'b0);
        // Three frames back to back, mixed modes
        run_stream(2, 3, 4'b0101, 1'b0, 0, 1'b1, 1'b0);
        // Output stalled while three frames arrive, then released
        run_stream(3, 3, 4'b0011, 1'b1, 100, 1'b0, 1'b1);

        // Reset while frame A drains and frame B is 10 beats in
        dout_ready = 1'b1;
        for (int b = 0; b < BEATS + 10; b++) begin
            din_valid = 1'b1;
            din_i = in_vec(b / BEATS + 2, b % BEATS, 1'b0);
            din_q = in_vec(b / BEATS + 2, b % BEATS, 1'b1);
            bitrev_en = 1'b1;
            @(posedge clk); #1;
        end
        chk("drain_before_rst", VW'(dout_valid), VW'(1'b1));
        #2 rst = 1'b1;
        #1;
        chk("midrst_dout_valid", VW'(dout_valid), VW'(1'b0));
        chk("midrst_din_ready", VW'(din_ready), VW'(1'b1));
        chk("midrst_dout_last", VW'(dout_last), VW'(1'b0));
        din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", VW'(dout_valid), VW'(1'b0));
        run_stream(1, 1, 4'b0001, 1'b0, 0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
